stopwatch_ctrl: RTL and testbench
=================================

Name: stopwatch_ctrl

Overview:
Control stage directly upstream of seconds_counter in the stopwatch datapath. Synchronizes raw start/stop/reset button levels and detects their rising edges. Runs an IDLE/RUNNING/PAUSED FSM and a 1 Hz prescaler. Drives seconds_counter's enable with a one-cycle tick per elapsed second and its clear with a one-cycle pulse.

Parameters:
TICK_DIV, 100000000, clk cycles per count_en tick (>=2); sim benches use 4
SYNC_STAGES, 2, synchronizer flop depth per button input (>=2)

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
start_btn  input  1  raw start button level, asynchronous to clk
stop_btn  input  1  raw stop button level, asynchronous to clk
reset_btn  input  1  raw reset button level, asynchronous to clk
count_en  output  1  one-cycle tick to seconds_counter enable
clear  output  1  one-cycle pulse to seconds_counter clear (and minutes stage)
state  output  2  current FSM state encoding
running  output  1  high when state==RUNNING

Behaviour:
- Reset (rst_n low, async): state=IDLE, prescaler=0, sync chains and edge-detect history=0. Outputs count_en=0, clear=0, state=IDLE, running=0.
- Each button: SYNC_STAGES-flop synchronizer, then rising-edge detect (sync_out & ~prev). This gives a 1-cycle press pulse SYNC_STAGES+1 clk edges after the input rises.
- A level held across reset release is seen as a press after release; this is intentional.
- No debounce here; inputs are assumed pre-debounced by board logic.
- Press pulse priority: reset > stop > start.
- FSM transitions (registered, take effect on the edge that samples the press pulse):
  - reset_p in any state -> IDLE; prescaler <= 0; clear <= 1 for exactly one cycle (also issued when already in IDLE).
  - IDLE + start_p -> RUNNING; prescaler <= 0.
  - RUNNING + stop_p -> PAUSED; prescaler holds its value.
  - PAUSED + start_p -> RUNNING; prescaler resumes from its held value, so the partial second is preserved.
  - Ignored presses: start_p in RUNNING, stop_p in IDLE or PAUSED.
  - stop_p and start_p in the same cycle: stop wins. RUNNING -> PAUSED; PAUSED stays PAUSED.
- Prescaler (width $clog2(TICK_DIV)):
  - Increments only while state==RUNNING.
  - At TICK_DIV-1 it wraps to 0.
  - In that same edge, count_en <= 1 for one cycle, unless stop_p or reset_p is present in that cycle; the tick is then suppressed.
- First count_en after IDLE->RUNNING is registered exactly TICK_DIV cycles after the transition edge. Subsequent ticks have a period of exactly TICK_DIV.
- count_en and clear are registered, mutually exclusive, and never high for two consecutive cycles.
- running is decoded combinationally from the state register. The state encoding is never X after reset.
- Illegal state 2'b11 -> IDLE on the next edge with a clear pulse; this is a recovery path only.

Decomposition:
- Package stopwatch_pkg holds:
  - state typedef/localparams: ST_IDLE=2'b00, ST_RUNNING=2'b01, ST_PAUSED=2'b10;
  - default TICK_DIV constant, shared with seconds_counter benches.
- One sub-module, btn_sync_edge: SYNC_STAGES synchronizer plus rising-edge detector, 1 input -> 1 pulse. It is instantiated three times.
- FSM and prescaler stay in stopwatch_ctrl.

Test Plan (TICK_DIV=4, SYNC_STAGES=2):
- Reset release, no buttons -> state=00, count_en=0, clear=0 for 50 cycles.
- start_btn high 5 cycles -> state=01 three edges after rise. count_en pulses 4 cycles after the transition and then every 4 cycles. Over 40 cycles the tick count matches 40/4 within one tick.
- Running; stop press at prescaler=2, 20 cycles idle, then start press -> no count_en while PAUSED. First tick after resume arrives 2 cycles after re-entering RUNNING (held partial count).
- reset_btn press while RUNNING, timed to coincide with a tick -> clear=1 for one cycle, count_en=0 that cycle, state=00, prescaler=0. A reset press in IDLE also gives a single clear pulse.
- start and stop rising in the same cycle while RUNNING -> PAUSED. Same while PAUSED -> stays PAUSED. stop alone in IDLE -> no change.
- rst_n asserted mid-RUNNING for 1 cycle -> all outputs 0 immediately (async), state=00. After release, no ticks until a new start press.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch types and constants: FSM state encoding and the default
// 1 Hz prescaler division used by the control stage and its benches.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'b00,
    ST_RUNNING = 2'b01,
    ST_PAUSED  = 2'b10,
    ST_ILLEGAL = 2'b11
  } state_e;

  localparam int unsigned TICK_DIV_DEFAULT    = 100_000_000;
  localparam int unsigned SYNC_STAGES_DEFAULT = 2;

endpackage

// File: rtl/btn_sync_edge.sv
// Multi-flop synchronizer for one asynchronous button level followed by a
// rising-edge detector producing a single-cycle press pulse.
module btn_sync_edge
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic press_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign press_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control stage: button press detection, IDLE/RUNNING/PAUSED FSM
// and 1 Hz prescaler driving seconds_counter's enable and clear.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned TICK_DIV    = TICK_DIV_DEFAULT,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start_btn,
  input  logic       stop_btn,
  input  logic       reset_btn,
  output logic       count_en,
  output logic       clear,
  output logic [1:0] state,
  output logic       running
);

  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);

  logic start_p, stop_p, reset_p;

  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_start (
    .clk(clk), .rst_n(rst_n), .btn_i(start_btn), .press_o(start_p)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_stop (
    .clk(clk), .rst_n(rst_n), .btn_i(stop_btn), .press_o(stop_p)
  );
  btn_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_reset (
    .clk(clk), .rst_n(rst_n), .btn_i(reset_btn), .press_o(reset_p)
  );

  state_e        state_q;
  logic [PW-1:0] presc_q;
  logic          count_en_q;
  logic          clear_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      presc_q    <= '0;
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      count_en_q <= 1'b0;
      clear_q    <= 1'b0;
      if (reset_p) begin
        state_q <= ST_IDLE;
        presc_q <= '0;
        clear_q <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (start_p && !stop_p) begin
              state_q <= ST_RUNNING;
              presc_q <= '0;
            end
          end
          ST_RUNNING: begin
            // A stop freezes the prescaler so the partial second survives the pause
            if (stop_p) begin
              state_q <= ST_PAUSED;
            end else if (presc_q == PRESC_MAX) begin
              presc_q    <= '0;
              count_en_q <= 1'b1;
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
          ST_PAUSED: begin
            if (start_p && !stop_p) begin
              state_q <= ST_RUNNING;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            clear_q <= 1'b1;
          end
        endcase
      end
    end
  end

  assign count_en = count_en_q;
  assign clear    = clear_q;
  assign state    = state_q;
  assign running  = (state_q == ST_RUNNING);

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl with TICK_DIV=4, SYNC_STAGES=2:
// stimulus queues expected count_en/clear pulses, a monitor pops and compares.
module tb_stopwatch_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start_btn, stop_btn, reset_btn;
  logic       count_en, clear, running;
  logic [1:0] state;

  stopwatch_ctrl #(.TICK_DIV(TD), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .start_btn(start_btn), .stop_btn(stop_btn), .reset_btn(reset_btn),
    .count_en(count_en), .clear(clear), .state(state), .running(running)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int kind;  // 0 = count_en tick, 1 = clear pulse
    int cyc;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_ev(input int kind, input int c);
    ev_t e;
    e.kind = kind;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  // Monitor: every output pulse must match the head of the expected queue
  initial begin
    logic prev_en, prev_clr;
    ev_t  e;
    prev_en  = 1'b0;
    prev_clr = 1'b0;
    forever begin
      @(negedge clk);
      if (count_en || clear) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse: got en=%0b clr=%0b at cycle %0d, expected no pulse",
                   count_en, clear, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.kind != int'(clear) || e.cyc != cyc) begin
            errors++;
            $display("FAIL pulse_match: got kind=%0d at cycle %0d, expected kind=%0d at cycle %0d",
                     int'(clear), cyc, e.kind, e.cyc);
          end
        end
        chk("en_clr_exclusive", int'(count_en && clear), 0);
        chk("no_back_to_back", int'((count_en && prev_en) || (clear && prev_clr)), 0);
      end
      prev_en  = count_en;
      prev_clr = clear;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k, t, s, r, a, t2, d, t3, c0;
    rst_n = 1'b0; start_btn = 1'b0; stop_btn = 1'b0; reset_btn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_state", state, 0);
    chk("rst_count_en", count_en, 0);
    chk("rst_clear", clear, 0);
    chk("rst_running", running, 0);
    rst_n = 1'b1;
    c0 = cyc;
    wait_cyc(c0 + 50);
    chk("idle_50_state", state, 0);

    // Start: transition three edges after the rise, ticks every TD from there
    k = cyc; t = k + 3;
    start_btn = 1'b1;
    for (int i = 1; i <= 10; i++) push_ev(0, t + TD * i);
    wait_cyc(t - 1); chk("pre_start_state", state, 0);
    wait_cyc(t);     chk("start_state", state, 1); chk("start_running", running, 1);
    wait_cyc(k + 5); start_btn = 1'b0;

    // Stop lands with prescaler at 2
    wait_cyc(t + 40); stop_btn = 1'b1; s = t + 43;
    wait_cyc(s - 1); chk("pre_stop_state", state, 1);
    wait_cyc(s);     chk("stop_state", state, 2); chk("stop_running", running, 0);
    wait_cyc(s + 2); stop_btn = 1'b0;

    // Resume after 20 cycles: first tick 2 cycles later; reset coincides with third tick
    wait_cyc(s + 20); r = cyc + 3;
    start_btn = 1'b1;
    push_ev(0, r + 2); push_ev(0, r + 6); push_ev(1, r + 10);
    wait_cyc(r - 1); chk("paused_hold_state", state, 2);
    wait_cyc(r);     chk("resume_state", state, 1);
    wait_cyc(r + 1); start_btn = 1'b0;
    wait_cyc(r + 7); reset_btn = 1'b1;
    wait_cyc(r + 9); reset_btn = 1'b0;
    wait_cyc(r + 10);
    chk("reset_state", state, 0); chk("reset_clear", clear, 1); chk("reset_tick_suppressed", count_en, 0);
    wait_cyc(r + 11); chk("reset_clear_one_cycle", clear, 0);

    // Reset press while already IDLE
    wait_cyc(r + 20); reset_btn = 1'b1; push_ev(1, r + 23);
    wait_cyc(r + 22); reset_btn = 1'b0;
    wait_cyc(r + 23); chk("idle_reset_clear", clear, 1); chk("idle_reset_state", state, 0);
    wait_cyc(r + 24); chk("idle_reset_clear_one_cycle", clear, 0);

    // Simultaneous start+stop while RUNNING, then while PAUSED
    wait_cyc(r + 30); a = cyc; t2 = a + 3;
    start_btn = 1'b1;
    push_ev(0, t2 + 4); push_ev(0, t2 + 8);
    wait_cyc(a + 3); start_btn = 1'b0;
    wait_cyc(t2 + 8); start_btn = 1'b1; stop_btn = 1'b1;
    wait_cyc(t2 + 11); chk("both_running_state", state, 2);
    wait_cyc(t2 + 13); start_btn = 1'b0; stop_btn = 1'b0;
    wait_cyc(t2 + 20); start_btn = 1'b1; stop_btn = 1'b1;
    wait_cyc(t2 + 23); chk("both_paused_state", state, 2);
    wait_cyc(t2 + 26); chk("both_paused_state_later", state, 2);
    start_btn = 1'b0; stop_btn = 1'b0;

    // Back to IDLE, then stop alone must do nothing
    wait_cyc(t2 + 30); reset_btn = 1'b1; push_ev(1, t2 + 33);
    wait_cyc(t2 + 32); reset_btn = 1'b0;
    wait_cyc(t2 + 33); chk("back_idle_state", state, 0);
    wait_cyc(t2 + 36); stop_btn = 1'b1;
    wait_cyc(t2 + 39); chk("stop_in_idle_state", state, 0);
    wait_cyc(t2 + 40); stop_btn = 1'b0;
    wait_cyc(t2 + 45); chk("stop_in_idle_state_later", state, 0);

    // Async reset asserted while count_en is high
    wait_cyc(t2 + 50); d = cyc; t3 = d + 3;
    start_btn = 1'b1; push_ev(0, t3 + 4);
    wait_cyc(d + 3); start_btn = 1'b0;
    wait_cyc(t3 + 4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_running", running, 0);
    chk("async_rst_count_en", count_en, 0);
    chk("async_rst_clear", clear, 0);
    @(negedge clk); rst_n = 1'b1;
    wait_cyc(t3 + 30); chk("post_rst_state", state, 0);

    chk("all_pulses_seen", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
